// File: rtl/mips_issue_unit_if.sv
// mips_issue_unit_if
//   This interface groups the instruction handshake, the ALU drive and return bus,
//   the data-memory channel, the branch and illegal-instruction flags, and the
//   register-file debug port of the MIPS issue unit.
//   The issue unit connects through the "slave" modport. The environment (the
//   instruction source, the ALU, the memory and the debug host) connects through
//   the "master" modport.
//
//   Signal summary, with direction seen from the issue unit:
//     instr[31:0]          in   instruction word
//     instr_valid          in   instr is valid
//     instr_ready          out  unit can accept an instruction
//     alu_opcode[5:0]      out  registered opcode to the ALU
//     alu_funct[5:0]       out  registered funct to the ALU
//     alu_in1[31:0]        out  registered operand 1
//     alu_in2[31:0]        out  registered operand 2
//     alu_result[31:0]     in   combinational ALU result
//     alu_rw               in   ALU register-write indication
//     mem_req              out  data memory request
//     mem_we               out  1 = store, 0 = load
//     mem_addr[31:0]       out  byte address
//     mem_wdata[31:0]      out  store data
//     mem_rdata[31:0]      in   load data, valid with mem_ack
//     mem_ack              in   memory completes the request
//     branch_taken         out  one-cycle pulse when the beq condition is true
//     branch_offset[31:0]  out  sext(imm)<<2, valid with branch_taken
//     illegal              out  one-cycle pulse for an unsupported instruction
//     dbg_addr[4:0]        in   register file debug read index
//     dbg_data[31:0]       out  combinational read of reg[dbg_addr]
interface mips_issue_unit_if;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [5:0]  alu_opcode;
   logic [5:0]  alu_funct;
   logic [31:0] alu_in1;
   logic [31:0] alu_in2;
   logic [31:0] alu_result;
   logic        alu_rw;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        branch_taken;
   logic [31:0] branch_offset;
   logic        illegal;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;

   modport slave (
      input  instr, instr_valid, alu_result, alu_rw, mem_rdata, mem_ack, dbg_addr,
      output instr_ready, alu_opcode, alu_funct, alu_in1, alu_in2,
             mem_req, mem_we, mem_addr, mem_wdata,
             branch_taken, branch_offset, illegal, dbg_data
   );

   modport master (
      output instr, instr_valid, alu_result, alu_rw, mem_rdata, mem_ack, dbg_addr,
      input  instr_ready, alu_opcode, alu_funct, alu_in1, alu_in2,
             mem_req, mem_we, mem_addr, mem_wdata,
             branch_taken, branch_offset, illegal, dbg_data
   );
endinterface

// File: rtl/mips_issue_unit.sv
// mips_issue_unit
//   This is the decode and issue front end for a single-cycle combinational ALU.
//   It accepts one MIPS instruction per valid/ready handshake and reads its
//   operands from an internal 32x32 register file, in which r0 is hardwired to 0.
//   It then drives the ALU, and writes back either the ALU result or the load data.
//   For lw/sw it issues a data-memory request. For a taken beq it raises a pulse.
//
//   Ports:
//     clk    rising-edge system clock
//     reset  asynchronous active-high reset; it aborts any operation in flight
//     bus    mips_issue_unit_if.slave; it carries the instruction handshake, the ALU
//            bus, the memory channel, the branch/illegal flags and the debug read port
//
//   Sequence: IDLE -> DECODE -> EXEC -> (MEM until mem_ack) -> IDLE.
//   An illegal instruction returns from DECODE straight to IDLE.
module mips_issue_unit #(
   parameter int NREGS = 32,
   parameter int IMM_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   mips_issue_unit_if.slave bus
);
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      EXEC   = 2'd2,
      MEM    = 2'd3
   } state_t;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [31:0] instr_r;
   logic [31:0] regs_r [NREGS];

   logic [5:0]  alu_opcode_r;
   logic [5:0]  alu_funct_r;
   logic [31:0] alu_in1_r;
   logic [31:0] alu_in2_r;
   logic        mem_req_r;
   logic        mem_we_r;
   logic [31:0] mem_addr_r;
   logic [31:0] mem_wdata_r;
   logic        branch_taken_r;
   logic [31:0] branch_offset_r;
   logic        illegal_r;

   logic [5:0]  opcode_s;
   logic [4:0]  rs_s;
   logic [4:0]  rt_s;
   logic [4:0]  rd_s;
   logic [5:0]  funct_s;
   logic [31:0] imm_sext_s;
   logic        legal_s;
   logic        is_mem_op_s;

   logic        wb_en_s;
   logic [4:0]  wb_idx_s;
   logic [31:0] wb_data_s;

   // This function returns 1 for the supported instructions: the four R-type
   // functs, lw, sw and beq.
   function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
      logic ok;
      case (op)
         OP_RTYPE: begin
            case (fn)
               FN_ADD, FN_SUB, FN_AND, FN_OR: ok = 1'b1;
               default:                       ok = 1'b0;
            endcase
         end
         OP_LW, OP_SW, OP_BEQ: ok = 1'b1;
         default:              ok = 1'b0;
      endcase
      return ok;
   endfunction

   assign opcode_s    = instr_r[31:26];
   assign rs_s        = instr_r[25:21];
   assign rt_s        = instr_r[20:16];
   assign rd_s        = instr_r[15:11];
   assign funct_s     = instr_r[5:0];
   assign imm_sext_s  = {{(32 - IMM_W){instr_r[IMM_W-1]}}, instr_r[IMM_W-1:0]};
   assign legal_s     = is_legal(opcode_s, funct_s);
   assign is_mem_op_s = (opcode_s == OP_LW) || (opcode_s == OP_SW);

   assign bus.instr_ready   = (state_r == IDLE);
   assign bus.alu_opcode    = alu_opcode_r;
   assign bus.alu_funct     = alu_funct_r;
   assign bus.alu_in1       = alu_in1_r;
   assign bus.alu_in2       = alu_in2_r;
   assign bus.mem_req       = mem_req_r;
   assign bus.mem_we        = mem_we_r;
   assign bus.mem_addr      = mem_addr_r;
   assign bus.mem_wdata     = mem_wdata_r;
   assign bus.branch_taken  = branch_taken_r;
   assign bus.branch_offset = branch_offset_r;
   assign bus.illegal       = illegal_r;
   // r0 is never written and resets to zero, so a plain array read already returns 0 for it.
   assign bus.dbg_data      = regs_r[bus.dbg_addr];

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.instr_valid) state_nxt_s = DECODE;
            else                 state_nxt_s = IDLE;
         end
         DECODE: begin
            if (legal_s) state_nxt_s = EXEC;
            else         state_nxt_s = IDLE;
         end
         EXEC: begin
            if (is_mem_op_s) state_nxt_s = MEM;
            else             state_nxt_s = IDLE;
         end
         MEM: begin
            if (bus.mem_ack) state_nxt_s = IDLE;
            else             state_nxt_s = MEM;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Register-file write port. It is fed from two sources: the R-type result at
   // the end of EXEC, and the load data on the mem_ack cycle.
   always_comb begin
      wb_en_s   = 1'b0;
      wb_idx_s  = 5'd0;
      wb_data_s = 32'd0;
      if ((state_r == EXEC) && (opcode_s == OP_RTYPE) && bus.alu_rw && (rd_s != 5'd0)) begin
         wb_en_s   = 1'b1;
         wb_idx_s  = rd_s;
         wb_data_s = bus.alu_result;
      end else if ((state_r == MEM) && bus.mem_ack && (opcode_s == OP_LW) && (rt_s != 5'd0)) begin
         wb_en_s   = 1'b1;
         wb_idx_s  = rt_s;
         wb_data_s = bus.mem_rdata;
      end else begin
         wb_en_s   = 1'b0;
      end
   end

   // Register file storage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= 32'd0;
         end
      end else if (wb_en_s) begin
         regs_r[wb_idx_s] <= wb_data_s;
      end
   end

   // Datapath: instruction latch, ALU drive, memory request, branch and illegal flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_r         <= 32'd0;
         alu_opcode_r    <= 6'd0;
         alu_funct_r     <= 6'd0;
         alu_in1_r       <= 32'd0;
         alu_in2_r       <= 32'd0;
         mem_req_r       <= 1'b0;
         mem_we_r        <= 1'b0;
         mem_addr_r      <= 32'd0;
         mem_wdata_r     <= 32'd0;
         branch_taken_r  <= 1'b0;
         branch_offset_r <= 32'd0;
         illegal_r       <= 1'b0;
      end else begin
         // The branch and illegal flags are single-cycle pulses.
         branch_taken_r <= 1'b0;
         illegal_r      <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.instr_valid) instr_r <= bus.instr;
            end
            DECODE: begin
               if (legal_s) begin
                  alu_opcode_r <= opcode_s;
                  alu_funct_r  <= funct_s;
                  alu_in1_r    <= regs_r[rs_s];
                  if (is_mem_op_s) alu_in2_r <= imm_sext_s;
                  else             alu_in2_r <= regs_r[rt_s];
               end else begin
                  // For an illegal instruction the ALU bus keeps its previous contents.
                  illegal_r <= 1'b1;
               end
            end
            EXEC: begin
               case (opcode_s)
                  OP_LW: begin
                     mem_req_r  <= 1'b1;
                     mem_we_r   <= 1'b0;
                     mem_addr_r <= bus.alu_result;
                  end
                  OP_SW: begin
                     mem_req_r   <= 1'b1;
                     mem_we_r    <= 1'b1;
                     mem_addr_r  <= bus.alu_result;
                     mem_wdata_r <= regs_r[rt_s];
                  end
                  OP_BEQ: begin
                     // The compare is done here; it does not depend on the ALU result.
                     branch_taken_r  <= (regs_r[rs_s] == regs_r[rt_s]);
                     branch_offset_r <= {imm_sext_s[29:0], 2'b00};
                  end
                  default: begin
                  end
               endcase
            end
            MEM: begin
               if (bus.mem_ack) mem_req_r <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mips_issue_unit.sv
// tb_mips_issue_unit
//   This is a directed, self-checking bench for mips_issue_unit. A small behavioural
//   ALU drives alu_result/alu_rw from the unit's alu_* outputs. The inputs are driven
//   on the falling edge, and the outputs are sampled on or shortly after it.
module tb_mips_issue_unit;
   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   mips_issue_unit_if bus ();

   mips_issue_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference ALU: the R-type ops write back; lw/sw compute an address; beq subtracts.
   always_comb begin
      bus.alu_result = 32'd0;
      bus.alu_rw     = 1'b0;
      case (bus.alu_opcode)
         6'b000000: begin
            case (bus.alu_funct)
               6'b100000: begin bus.alu_result = bus.alu_in1 + bus.alu_in2; bus.alu_rw = 1'b1; end
               6'b100010: begin bus.alu_result = bus.alu_in1 - bus.alu_in2; bus.alu_rw = 1'b1; end
               6'b100100: begin bus.alu_result = bus.alu_in1 & bus.alu_in2; bus.alu_rw = 1'b1; end
               6'b100101: begin bus.alu_result = bus.alu_in1 | bus.alu_in2; bus.alu_rw = 1'b1; end
               default:   bus.alu_rw = 1'b0;
            endcase
         end
         6'b100011, 6'b101011: bus.alu_result = bus.alu_in1 + bus.alu_in2;
         6'b000100:            bus.alu_result = bus.alu_in1 - bus.alu_in2;
         default:              bus.alu_result = 32'd0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic chk_reg(input logic [4:0] idx, input logic [31:0] exp, input string tag);
      bus.dbg_addr = idx;
      #1;
      check(tag, bus.dbg_data, exp);
   endtask

   // This task is called from IDLE. It presents the instruction, waits for the
   // accept edge, and returns on the falling edge of cycle 1 (DECODE).
   task automatic issue(input logic [31:0] w);
      check("ready_before_issue", 32'(bus.instr_ready), 32'd1);
      bus.instr       = w;
      bus.instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.instr_valid = 1'b0;
      check("ready_cycle1", 32'(bus.instr_ready), 32'd0);
   endtask

   // This task is called on the falling edge of the first MEM cycle. It checks that
   // the request is held for 'hold' cycles, with the ack raised in the last of them.
   task automatic mem_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic chk_wdata, input logic [31:0] rdata, input int hold);
      for (int i = 0; i < hold; i++) begin
         check("mem_req_held", 32'(bus.mem_req), 32'd1);
         check("mem_addr", bus.mem_addr, addr);
         check("mem_we", 32'(bus.mem_we), 32'(we));
         if (chk_wdata) check("mem_wdata", bus.mem_wdata, wdata);
         if (i == hold - 1) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rdata;
         end
         @(negedge clk);
      end
      bus.mem_ack = 1'b0;
      check("mem_req_drop", 32'(bus.mem_req), 32'd0);
      check("ready_after_mem", 32'(bus.instr_ready), 32'd1);
   endtask

   initial begin
      reset           = 1'b1;
      bus.instr       = 32'd0;
      bus.instr_valid = 1'b0;
      bus.mem_rdata   = 32'd0;
      bus.mem_ack     = 1'b0;
      bus.dbg_addr    = 5'd0;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(bus.instr_ready), 32'd1);
      check("rst_mem_req", 32'(bus.mem_req), 32'd0);
      check("rst_alu_in1", bus.alu_in1, 32'd0);
      check("rst_illegal", 32'(bus.illegal), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk_reg(5'd1, 32'd0, "rst_r1");

      // lw r1,4(r0), with the ack arriving after 3 cycles
      issue(32'h8C010004);
      @(negedge clk);
      check("lw_alu_in2", bus.alu_in2, 32'd4);
      @(negedge clk);
      mem_txn(1'b0, 32'd4, 32'd0, 1'b0, 32'd5, 3);
      chk_reg(5'd1, 32'd5, "lw_r1");

      // lw r2,8(r0) = 7
      issue(32'h8C020008);
      repeat (2) @(negedge clk);
      mem_txn(1'b0, 32'd8, 32'd0, 1'b0, 32'd7, 1);
      chk_reg(5'd2, 32'd7, "lw_r2");

      // add r3,r1,r2
      issue(32'h00221820);
      @(negedge clk);
      check("add_ready_c2", 32'(bus.instr_ready), 32'd0);
      check("add_alu_in1", bus.alu_in1, 32'd5);
      check("add_alu_in2", bus.alu_in2, 32'd7);
      chk_reg(5'd3, 32'd0, "add_r3_not_yet");
      @(negedge clk);
      chk_reg(5'd3, 32'd12, "add_r3");

      // sub r4,r1,r2
      issue(32'h00222022);
      repeat (2) @(negedge clk);
      chk_reg(5'd4, 32'hFFFFFFFE, "sub_r4");

      // sw r3,8(r1)
      issue(32'hAC230008);
      @(negedge clk);
      check("sw_alu_in2", bus.alu_in2, 32'd8);
      @(negedge clk);
      mem_txn(1'b1, 32'd13, 32'd12, 1'b1, 32'd0, 2);
      chk_reg(5'd3, 32'd12, "sw_r3_kept");
      chk_reg(5'd4, 32'hFFFFFFFE, "sw_r4_kept");

      // beq r1,r1,-2 (taken)
      issue(32'h1021FFFE);
      @(negedge clk);
      check("beq_t_c2", 32'(bus.branch_taken), 32'd0);
      @(negedge clk);
      check("beq_t_pulse", 32'(bus.branch_taken), 32'd1);
      check("beq_t_offset", bus.branch_offset, 32'hFFFFFFF8);
      @(negedge clk);
      check("beq_t_pulse_end", 32'(bus.branch_taken), 32'd0);

      // beq r1,r2,-2 (not taken)
      issue(32'h1022FFFE);
      repeat (2) @(negedge clk);
      check("beq_nt_c3", 32'(bus.branch_taken), 32'd0);
      @(negedge clk);
      check("beq_nt_c4", 32'(bus.branch_taken), 32'd0);

      // add r0,r1,r2: the write to r0 is discarded
      issue(32'h00220020);
      repeat (2) @(negedge clk);
      chk_reg(5'd0, 32'd0, "r0_zero");

      // opcode 000010 (illegal)
      issue(32'h08000000);
      check("ill_c1", 32'(bus.illegal), 32'd0);
      @(negedge clk);
      check("ill_pulse", 32'(bus.illegal), 32'd1);
      check("ill_ready", 32'(bus.instr_ready), 32'd1);
      check("ill_mem_req", 32'(bus.mem_req), 32'd0);
      check("ill_alu_in1_kept", bus.alu_in1, 32'd5);
      check("ill_alu_opcode_kept", 32'(bus.alu_opcode), 32'd0);
      @(negedge clk);
      check("ill_pulse_end", 32'(bus.illegal), 32'd0);

      // R-type with an unsupported funct (100001)
      issue(32'h00221821);
      @(negedge clk);
      check("ill_fn_pulse", 32'(bus.illegal), 32'd1);
      check("ill_fn_funct_kept", 32'(bus.alu_funct), 32'h20);
      chk_reg(5'd3, 32'd12, "ill_fn_r3_kept");
      @(negedge clk);

      // Reset applied while a load is waiting for mem_ack
      issue(32'h8C010004);
      repeat (2) @(negedge clk);
      check("abort_mem_req_before", 32'(bus.mem_req), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("abort_mem_req_async", 32'(bus.mem_req), 32'd0);
      chk_reg(5'd1, 32'd0, "abort_r1");
      chk_reg(5'd3, 32'd0, "abort_r3");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("abort_ready", 32'(bus.instr_ready), 32'd1);
      check("abort_mem_req_after", 32'(bus.mem_req), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mips_issue_unit.md
Name: mips_issue_unit

Overview:
Decode/issue front end for the single-cycle-combinational ALU. It drives that ALU's opcode/funct/in1/in2 inputs and consumes its result/rw outputs. It accepts one 32-bit MIPS instruction per valid/ready handshake and reads operands from an internal 32x32 register file. It then writes back ALU or load results, issues data-memory requests for lw/sw, and flags taken beq branches.

Parameters:
NREGS, 32, register file depth (r0 hardwired to zero)
IMM_W, 16, immediate field width, sign-extended to 32

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
instr  in  32  instruction word
instr_valid  in  1  instr is valid
instr_ready  out  1  unit can accept an instruction
alu_opcode  out  6  registered opcode to ALU
alu_funct  out  6  registered funct to ALU
alu_in1  out  32  registered operand 1 (rs value)
alu_in2  out  32  registered operand 2 (rt value or sign-extended imm)
alu_result  in  32  ALU result, combinational from alu_* outputs
alu_rw  in  1  ALU register-write indication
mem_req  out  1  data memory request
mem_we  out  1  1 = store, 0 = load
mem_addr  out  32  byte address
mem_wdata  out  32  store data
mem_rdata  in  32  load data, valid with mem_ack
mem_ack  in  1  memory completes request
branch_taken  out  1  one-cycle pulse, beq condition true
branch_offset  out  32  sext(imm)<<2, valid with branch_taken
illegal  out  1  one-cycle pulse, unsupported instruction
dbg_addr  in  5  register file debug read index
dbg_data  out  32  combinational read of reg[dbg_addr]

Behaviour:
- Reset (async): state IDLE; all registers cleared, including the instruction latch, alu_* outputs, mem_* outputs, branch_taken, branch_offset, illegal and all 32 regfile entries. instr_ready=1 in IDLE only.
- Supported instructions: R-type (opcode 000000) with funct 100000 add, 100010 sub, 100100 and, 100101 or; lw 100011; sw 101011; beq 000100. Any other opcode, or R-type with another funct, is illegal.
- IDLE: instr_ready=1. On instr_valid&instr_ready, latch instr and go to DECODE.
- DECODE (1 cycle): read rs/rt and register alu_opcode, alu_funct, alu_in1=reg[rs].
  - alu_in2 = reg[rt] for R-type/beq; sext(imm) for lw/sw.
  - Illegal: pulse illegal the next cycle, no state change elsewhere, go to IDLE.
  - Otherwise go to EXEC.
- EXEC (1 cycle): sample alu_result/alu_rw.
  - R-type: if alu_rw=1 and rd!=0, reg[rd]<=alu_result at the end of EXEC. Go to IDLE.
  - lw: mem_req=1, mem_we=0, mem_addr=alu_result. Go to MEM.
  - sw: mem_req=1, mem_we=1, mem_addr=alu_result, mem_wdata=reg[rt]. Go to MEM.
  - beq: the equality compare is internal (reg[rs]==reg[rt]); the unit does not depend on the ALU result. If equal, pulse branch_taken for 1 cycle with branch_offset. Go to IDLE.
- MEM: hold mem_req, mem_we, mem_addr and mem_wdata stable until mem_ack. On the ack cycle:
  - lw: reg[rt]<=mem_rdata if rt!=0.
  - mem_req drops the next cycle; go to IDLE.
  - mem_ack outside MEM is ignored.
- Latency: accept edge -> R-type writeback at the end of cycle 2; instr_ready returns in cycle 3.
- r0 reads as 0 always; writes to r0 are discarded.
- Reset asserted mid-operation aborts immediately: mem_req=0, pending write lost.
- Address arithmetic wraps mod 2^32.

Test Plan:
- Reset, then lw r1,4(r0)=0x8C010004 with mem_rdata=5, ack after 3 cycles -> mem_req high with mem_addr=4 held 3 cycles; dbg r1=5.
- Load r2=7, then add r3,r1,r2=0x00221820 -> alu_in1=5, alu_in2=7; r3=12 at the end of cycle 2; instr_ready low for cycles 1-2. Then sub r4,r1,r2=0x00222022 -> r4=0xFFFFFFFE.
- sw r3,8(r1)=0xAC230008 -> mem_req=1, mem_we=1, mem_addr=13, mem_wdata=12; no regfile change.
- beq r1,r1,-2=0x1021FFFE -> branch_taken 1-cycle pulse, branch_offset=0xFFFFFFF8. beq r1,r2 -> no pulse.
- add r0,r1,r2=0x00220020 -> r0 stays 0. Opcode 000010 (0x08000000) -> illegal pulse, no write, no mem_req.
- Assert reset while mem_req=1 -> mem_req=0 asynchronously, all regs 0, instr_ready=1 after release.
